// File: rtl/sram_pkg.sv
// Shared widths and the reader state encoding for the 256x8 SRAM read-side initiator.
package sram_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int LAT_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_VALID,
    ST_DONE
  } rd_state_e;
endpackage

// File: rtl/sram_rd_lat_cnt.sv
// Read-latency down-counter: load primes it to RD_LAT, expire flags the final wait cycle.
module sram_rd_lat_cnt
  import sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_W'(RD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/sram_burst_reader.sv
// Burst reader: streams len words from base out of the SRAM over valid/ready, then pulses done.
// Optional running checksum is built only when SRAM_READER_CHECKSUM_EN is defined.
module sram_burst_reader
  import sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_EN,
  input  logic [DATA_W-1:0] mem_out_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lat_load, lat_expire;
  logic [ADDR_W-1:0] addr_inc, cnt_inc;

  sram_rd_lat_cnt #(.RD_LAT(RD_LAT)) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (lat_load),
    .expire (lat_expire)
  );

  assign addr_inc = addr_q + 1'b1;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    done_d        = 1'b0;
    lat_load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = base;
          len_d  = len;
          cnt_d  = '0;
          if (len != '0) begin
            state_d       = ST_ADDR;
            mem_address_d = base;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        state_d  = ST_WAIT;
        lat_load = 1'b1;
      end
      ST_WAIT: begin
        if (lat_expire) begin
          rd_data_d  = mem_out_data;
          rd_valid_d = 1'b1;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        if (rd_ready) begin
          cnt_d      = cnt_inc;
          addr_d     = addr_inc;
          rd_valid_d = 1'b0;
          // The final word leaves mem_address on the last location actually read.
          if (cnt_inc == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d       = ST_ADDR;
            mem_address_d = addr_inc;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      mem_address_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef SRAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && start) begin
      csum_d = '0;
    end else if (state_q == ST_VALID && rd_ready) begin
      csum_d = csum_q + rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign mem_address = mem_address_q;
  assign mem_in_data = '0;
  assign mem_EN      = 1'b0;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: a table of bursts against a small SRAM model,
// plus hand-written reset-during-burst and reset-state sequences.
module tb_sram_burst_reader;
  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] len = '0;
  logic [7:0] mem_address;
  logic [7:0] mem_in_data;
  logic       mem_EN;
  logic [7:0] mem_out_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [256];
  logic [7:0] mem_pipe [RD_LAT];
  logic [7:0] got_d [256];
  logic [7:0] got_a [256];

  always #5 clk = ~clk;

  sram_burst_reader #(.RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base         (base),
    .len          (len),
    .mem_address  (mem_address),
    .mem_in_data  (mem_in_data),
    .mem_EN       (mem_EN),
    .mem_out_data (mem_out_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  // SRAM model: address registered, data out RD_LAT cycles later.
  always @(posedge clk) begin
    mem_pipe[0] <= mem[mem_address];
    for (int s = 1; s < RD_LAT; s++) mem_pipe[s] <= mem_pipe[s-1];
  end
  assign mem_out_data = mem_pipe[RD_LAT-1];

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    int         stall_idx;
    int         stall_n;
    int         mid_cyc;
    int         exp_first;
    logic [7:0] exp_last;
    logic [7:0] exp_sum;
    logic [7:0] exp_w [6];
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input int id);
    int cyc, nw, stalled, first_v, done_n, done_cyc, last_hs, stab_err, en_err;
    logic finished, busy_after, held;
    logic [7:0] held_d, held_a;
    int exp_sum;
    cyc = 0; nw = 0; stalled = 0; first_v = -1; done_n = 0; done_cyc = -1;
    last_hs = -1; stab_err = 0; en_err = 0; finished = 1'b0; busy_after = 1'b1;
    held = 1'b0; held_d = '0; held_a = '0;
    rd_ready = 1'b1;
    @(negedge clk);
    base = v.base; len = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 2000) begin
      start = (v.mid_cyc != 0 && cyc == v.mid_cyc);
      if (start) base = v.base + 8'd77;
      if (mem_EN !== 1'b0) en_err++;
      if (held && (rd_valid !== 1'b1 || rd_data !== held_d || mem_address !== held_a)) stab_err++;
      if (rd_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        finished = 1'b1;
      end
      if (rd_valid && nw == v.stall_idx && stalled < v.stall_n) begin
        rd_ready = 1'b0;
        stalled++;
      end else begin
        rd_ready = 1'b1;
      end
      held = rd_valid && !rd_ready;
      held_d = rd_data;
      held_a = mem_address;
      if (rd_valid && rd_ready && nw < 256) begin
        got_d[nw] = rd_data;
        got_a[nw] = mem_address;
        nw++;
        last_hs = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rd_ready = 1'b1;
    if (!finished) $display("FAIL burst%0d_timeout: got no done, expected done within budget", id);
    chk($sformatf("burst%0d_finished", id), int'(finished), 1);
    chk($sformatf("burst%0d_words", id), nw, int'(v.len));
    for (int k = 0; k < nw; k++) begin
      chk($sformatf("burst%0d_addr%0d", id, k), int'(got_a[k]), int'(8'(v.base + k[7:0])));
      if (k < 6) chk($sformatf("burst%0d_data%0d", id, k), int'(got_d[k]), int'(v.exp_w[k]));
    end
    if (nw > 0) chk($sformatf("burst%0d_last_addr", id), int'(got_a[nw-1]), int'(v.exp_last));
    chk($sformatf("burst%0d_done_count", id), done_n, 1);
    chk($sformatf("burst%0d_done_cycle", id), done_cyc, last_hs + 1);
    chk($sformatf("burst%0d_busy_after_done", id), int'(busy_after), 0);
    chk($sformatf("burst%0d_first_valid", id), first_v, v.exp_first);
    chk($sformatf("burst%0d_stall_stable", id), stab_err, 0);
    chk($sformatf("burst%0d_mem_en", id), en_err, 0);
`ifdef SRAM_READER_CHECKSUM_EN
    exp_sum = int'(v.exp_sum);
`else
    exp_sum = 0;
`endif
    chk($sformatf("burst%0d_checksum", id), int'(checksum), exp_sum);
    $display("burst %0d: base=%0d len=%0d words=%0d first_valid=%0d done_cyc=%0d checksum=%0d",
             id, v.base, v.len, nw, first_v, done_cyc, checksum);
  endtask

  initial begin
    int cyc, nw, done_n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'd115; mem[1] = 8'd95; mem[2] = 8'd80; mem[3] = 8'd95; mem[4] = 8'd80;

    vecs[0] = '{8'd0,   8'd5,   -1, 0, 0, 3,  8'd4, 8'd209, '{8'd115, 8'd95, 8'd80, 8'd95, 8'd80, 8'd0}};
    vecs[1] = '{8'd0,   8'd5,    2, 3, 0, 3,  8'd4, 8'd209, '{8'd115, 8'd95, 8'd80, 8'd95, 8'd80, 8'd0}};
    vecs[2] = '{8'd254, 8'd4,   -1, 0, 0, 3,  8'd1, 8'd207, '{8'd254, 8'd255, 8'd115, 8'd95, 8'd0, 8'd0}};
    vecs[3] = '{8'd0,   8'd0,   -1, 0, 0, -1, 8'd0, 8'd0,   '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{8'd1,   8'd3,   -1, 0, 5, 3,  8'd3, 8'd14,  '{8'd95, 8'd80, 8'd95, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{8'd2,   8'd255, -1, 0, 0, 3,  8'd0, 8'd232, '{8'd80, 8'd95, 8'd80, 8'd5, 8'd6, 8'd7}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_addr", int'(mem_address), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_checksum", int'(checksum), 0);
    chk("reset_in_data", int'(mem_in_data), 0);
    chk("reset_mem_en", int'(mem_EN), 0);
    $display("reset: busy=%0d rd_valid=%0d done=%0d mem_address=%0d", busy, rd_valid, done, mem_address);

    for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

    // Reset while the third word's read is outstanding.
    @(negedge clk);
    base = 8'd0; len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; nw = 0; done_n = 0;
    while (nw < 2 && cyc < 100) begin
      if (rd_valid) nw++;
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached", nw, 2);
    @(negedge clk);
    chk("rst_mid_busy_before", int'(busy), 1);
    chk("rst_mid_addr_before", int'(mem_address), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(rd_valid), 0);
    chk("rst_mid_addr", int'(mem_address), 0);
    chk("rst_mid_rd_data", int'(rd_data), 0);
    chk("rst_mid_checksum", int'(checksum), 0);
    for (int k = 0; k < 6; k++) begin
      if (done || rd_valid || busy) done_n++;
      @(negedge clk);
    end
    chk("rst_mid_quiet", done_n, 0);
    $display("reset mid-burst: busy=%0d rd_valid=%0d mem_address=%0d rd_data=%0d", busy, rd_valid, mem_address, rd_data);
    run_burst(vecs[0], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
